// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data access.
// The data side has fixed priority; each access runs IDLE -> BUSY -> DONE with no preemption.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_valid,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic [31:0]      dm_rdata,
  output logic             dm_valid,
  output logic             stall_if,
  output logic             stall_dm,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int LW = $clog2(MEM_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             if_valid_q, if_valid_d;
  logic             dm_valid_q, dm_valid_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lat_cnt_d      = lat_cnt_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rdata_d     = if_rdata_q;
    dm_rdata_d     = dm_rdata_q;
    if_valid_d     = 1'b0;
    dm_valid_d     = 1'b0;
    conflict_cnt_d = conflict_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (if_req && dm_req) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        lat_cnt_d = '0;
        if (dm_req) begin
          owner_d     = OWN_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = S_BUSY;
        end else if (if_req) begin
          owner_d    = OWN_IF;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // mem_we_q is still set only during C0, so it marks a store completing in one cycle
        if (lat_cnt_q == '0 && mem_we_q) begin
          dm_valid_d = 1'b1;
          state_d    = S_DONE;
        end else if (lat_cnt_q == LW'(MEM_LAT)) begin
          if (owner_q == OWN_DM) begin
            dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_IF;
      lat_cnt_q      <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      if_valid_q     <= 1'b0;
      dm_valid_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      lat_cnt_q      <= lat_cnt_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rdata_q     <= if_rdata_d;
      dm_rdata_q     <= dm_rdata_d;
      if_valid_q     <= if_valid_d;
      dm_valid_q     <= dm_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign if_valid     = if_valid_q;
  assign dm_valid     = dm_valid_q;
  assign stall_if     = if_req & ~if_valid_q;
  assign stall_dm     = dm_req & ~dm_valid_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency memory model; a second
// instance with CNT_W=2 shares all inputs to exercise conflict counter wrap.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rdata;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, stall_if, stall_dm, mem_en, mem_we;
  logic [7:0]  conflict_cnt;

  logic [31:0] c2_if_rdata, c2_dm_rdata, c2_mem_addr, c2_mem_wdata;
  logic        c2_if_valid, c2_dm_valid, c2_stall_if, c2_stall_dm, c2_mem_en, c2_mem_we;
  logic [1:0]  c2_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(c2_if_rdata), .if_valid(c2_if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(c2_dm_rdata), .dm_valid(c2_dm_valid),
    .stall_if(c2_stall_if), .stall_dm(c2_stall_dm),
    .mem_en(c2_mem_en), .mem_we(c2_mem_we), .mem_addr(c2_mem_addr), .mem_wdata(c2_mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(c2_conflict_cnt)
  );

  // Word-addressed memory: write commits at the end of the mem_en cycle, read data
  // appears two cycles after the mem_en cycle.
  logic [31:0] mem [0:255];
  logic [31:0] rd_p1, rd_p2;

  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'h0050_0093;
      mem[8'h40] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_p1 <= mem[mem_addr[9:2]];
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_dm_valid", 32'(dm_valid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_conflict", 32'(conflict_cnt), 32'd0);

    // 1. Fetch only
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    check("t1_stall_if_req", 32'(stall_if), 32'd1);
    tick();
    check("t1_mem_en", 32'(mem_en), 32'd1);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    check("t1_mem_addr", mem_addr, 32'h40);
    for (int k = 2; k <= 3; k++) begin
      tick();
      check("t1_no_valid", 32'(if_valid), 32'd0);
      check("t1_stall_if", 32'(stall_if), 32'd1);
    end
    tick();
    check("t1_if_valid", 32'(if_valid), 32'd1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_stall_if_done", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    tick();
    check("t1_valid_pulse", 32'(if_valid), 32'd0);

    // 2. Simultaneous requests: DM first, then IF
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    tick();
    check("t2_grant_dm_addr", mem_addr, 32'h100);
    check("t2_conflict", 32'(conflict_cnt), 32'd1);
    check("t2_conflict_c2", 32'(c2_conflict_cnt), 32'd1);
    tick(); tick(); tick();
    check("t2_dm_valid", 32'(dm_valid), 32'd1);
    check("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("t2_if_not_valid", 32'(if_valid), 32'd0);
    check("t2_stall_if", 32'(stall_if), 32'd1);
    dm_req = 1'b0;
    tick();
    check("t2_idle_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("t2_grant_if_addr", mem_addr, 32'h40);
    check("t2_mem_en_if", 32'(mem_en), 32'd1);
    tick(); tick(); tick();
    check("t2_if_valid", 32'(if_valid), 32'd1);
    check("t2_if_rdata", if_rdata, 32'h0050_0093);
    check("t2_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);
    check("t2_conflict_once", 32'(conflict_cnt), 32'd1);
    if_req = 1'b0;
    tick();

    // 3. Store then load back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
    tick();
    check("t3_mem_en", 32'(mem_en), 32'd1);
    check("t3_mem_we", 32'(mem_we), 32'd1);
    check("t3_mem_addr", mem_addr, 32'h80);
    check("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    check("t3_no_valid_c0", 32'(dm_valid), 32'd0);
    tick();
    check("t3_dm_valid", 32'(dm_valid), 32'd1);
    check("t3_mem_en_off", 32'(mem_en), 32'd0);
    check("t3_mem_we_off", 32'(mem_we), 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    dm_req = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    check("t3_load_no_valid", 32'(dm_valid), 32'd0);
    tick();
    check("t3_load_valid", 32'(dm_valid), 32'd1);
    check("t3_load_rdata", dm_rdata, 32'h1234_5678);
    dm_req = 1'b0;
    tick();

    // 4. DM request arrives during a fetch: no preemption
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    dm_req = 1'b1; dm_addr = 32'h100;
    #1;
    check("t4_stall_dm_c0", 32'(stall_dm), 32'd1);
    tick();
    check("t4_stall_dm_c1", 32'(stall_dm), 32'd1);
    check("t4_mem_en_c1", 32'(mem_en), 32'd0);
    tick();
    check("t4_stall_dm_c2", 32'(stall_dm), 32'd1);
    tick();
    check("t4_if_valid", 32'(if_valid), 32'd1);
    check("t4_dm_not_valid", 32'(dm_valid), 32'd0);
    check("t4_stall_dm_done", 32'(stall_dm), 32'd1);
    if_req = 1'b0;
    tick();
    check("t4_idle_no_grant", 32'(mem_en), 32'd0);
    check("t4_stall_dm_idle", 32'(stall_dm), 32'd1);
    tick();
    check("t4_dm_grant", 32'(mem_en), 32'd1);
    check("t4_dm_addr", mem_addr, 32'h100);
    tick(); tick(); tick();
    check("t4_dm_valid", 32'(dm_valid), 32'd1);
    check("t4_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    tick();

    // 5. Reset in the second BUSY cycle of a load
    dm_req = 1'b1; dm_addr = 32'h40;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_mem_en", 32'(mem_en), 32'd0);
    check("t5_dm_valid", 32'(dm_valid), 32'd0);
    check("t5_dm_rdata", dm_rdata, 32'd0);
    check("t5_if_rdata", if_rdata, 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    tick();
    check("t5_regrant", 32'(mem_en), 32'd1);
    check("t5_no_stale_valid", 32'(dm_valid), 32'd0);
    tick(); tick();
    check("t5_no_valid_c2", 32'(dm_valid), 32'd0);
    tick();
    check("t5_dm_valid", 32'(dm_valid), 32'd1);
    check("t5_dm_rdata", dm_rdata, 32'h0050_0093);
    dm_req = 1'b0;
    tick();

    // 6. Five conflict cycles; CNT_W=2 instance wraps to 1
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_addr = 32'h100;
    tick();
    check("t6_first", 32'(conflict_cnt), 32'd1);
    for (int k = 0; k < 15; k++) tick();
    check("t6_four_c8", 32'(conflict_cnt), 32'd4);
    check("t6_wrap_zero_c2", 32'(c2_conflict_cnt), 32'd0);
    for (int k = 0; k < 5; k++) tick();
    check("t6_five_c8", 32'(conflict_cnt), 32'd5);
    check("t6_five_c2", 32'(c2_conflict_cnt), 32'd1);
    if_req = 1'b0; dm_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t6_final_c2", 32'(c2_conflict_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
